// File: rtl/linmem_arbiter_pkg.sv
// Shared definitions for the linear-memory arbiter: owner and state encodings,
// default widths and the out-of-range address helper.
package linmem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 10;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 8;
    localparam int unsigned CORE_ADDR_WIDTH  = 32;

    // Which requester the read returning this cycle belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2,
        OWN_OOB  = 2'd3
    } owner_t;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // True when any core address bit above the memory depth is set
    function automatic logic core_addr_oob(input logic [CORE_ADDR_WIDTH-1:0] addr,
                                           input int unsigned aw);
        return (addr >> aw) != '0;
    endfunction

endpackage

// File: rtl/linmem_arbiter_if.sv
// Bundle of core, host and memory-side signals around the linear-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface linmem_arbiter_if
    import linmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                       core_re;
    logic                       core_we;
    logic [CORE_ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0]      core_wdata;
    logic                       core_stall;
    logic [DATA_WIDTH-1:0]      core_rdata;
    logic                       core_rvld;
    logic                       oob_error;

    logic                       host_req;
    logic                       host_we;
    logic                       host_lock;
    logic [ADDR_WIDTH-1:0]      host_addr;
    logic [DATA_WIDTH-1:0]      host_wdata;
    logic                       host_gnt;
    logic [DATA_WIDTH-1:0]      host_rdata;
    logic                       host_rvld;

    logic                       mem_re;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic [DATA_WIDTH-1:0]      mem_rdata;

    modport slave (
        input  core_re, core_we, core_addr, core_wdata,
        output core_stall, core_rdata, core_rvld, oob_error,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvld,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_re, core_we, core_addr, core_wdata,
        input  core_stall, core_rdata, core_rvld, oob_error,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvld,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/linmem_starve_ctr.sv
// Saturating count of consecutive cycles the host has been refused memory access.
// at_limit tells the arbiter the host must be served this cycle.
module linmem_starve_ctr
    import linmem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int unsigned    CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] count;

    // Clear wins over increment; the count parks at LIMIT until the host is served
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + CW'(1);
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/linmem_arbiter.sv
// Shares the single-port linear memory between the core load/store path and the
// host loader port. Core has priority, host is starvation-protected, reads return in one cycle.
module linmem_arbiter
    import linmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           rst,
    linmem_arbiter_if.slave bus
);

    arb_state_t            state;
    owner_t                rd_owner;
    logic                  oob_error_q;
    logic [DATA_WIDTH-1:0] core_rdata_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;

    logic                  core_req;
    logic                  core_oob;
    logic                  core_acc;
    logic                  core_stall_c;
    logic                  host_gnt_c;
    logic                  at_limit;
    logic                  core_rvld_c;
    logic                  host_rvld_c;
    logic [DATA_WIDTH-1:0] core_rdata_c;
    logic [DATA_WIDTH-1:0] host_rdata_c;
    logic                  mem_re_c;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    assign core_req = bus.core_re | bus.core_we;
    assign core_oob = core_addr_oob(bus.core_addr, ADDR_WIDTH);

    // Nothing is granted while reset is held so all outputs read as idle
    always_comb begin
        host_gnt_c   = 1'b0;
        core_stall_c = 1'b0;
        if (!rst) begin
            if (state == ST_LOCK) begin
                host_gnt_c   = bus.host_req;
                core_stall_c = core_req;
            end else begin
                host_gnt_c   = bus.host_req && (at_limit || !core_req);
                core_stall_c = core_req && host_gnt_c;
            end
        end
    end

    assign core_acc = core_req && !core_stall_c && !rst;

    linmem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (!bus.host_req || host_gnt_c),
        .inc      (bus.host_req && !host_gnt_c),
        .at_limit (at_limit)
    );

    // An out-of-range core access is accepted but never reaches the memory
    always_comb begin
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (core_acc && !core_oob) begin
            mem_we_c    = bus.core_we;
            mem_re_c    = bus.core_re && !bus.core_we;
            mem_addr_c  = bus.core_addr[ADDR_WIDTH-1:0];
            mem_wdata_c = bus.core_wdata;
        end else if (host_gnt_c) begin
            mem_we_c    = bus.host_we;
            mem_re_c    = !bus.host_we;
            mem_addr_c  = bus.host_addr;
            mem_wdata_c = bus.host_wdata;
        end
    end

    always_comb begin
        core_rvld_c  = !rst && ((rd_owner == OWN_CORE) || (rd_owner == OWN_OOB));
        host_rvld_c  = !rst && (rd_owner == OWN_HOST);
        core_rdata_c = core_rdata_q;
        host_rdata_c = host_rdata_q;
        if (core_rvld_c) begin
            core_rdata_c = (rd_owner == OWN_OOB) ? '0 : bus.mem_rdata;
        end
        if (host_rvld_c) begin
            host_rdata_c = bus.mem_rdata;
        end
    end

    // Lock is only entered with no read returning, so a return is never orphaned
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_ARB;
            rd_owner     <= OWN_NONE;
            oob_error_q  <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            case (state)
                ST_ARB:  if (bus.host_lock && (rd_owner == OWN_NONE)) state <= ST_LOCK;
                ST_LOCK: if (!bus.host_lock) state <= ST_ARB;
                default: state <= ST_ARB;
            endcase

            if (core_acc && bus.core_re && !bus.core_we) begin
                rd_owner <= core_oob ? OWN_OOB : OWN_CORE;
            end else if (host_gnt_c && !bus.host_we) begin
                rd_owner <= OWN_HOST;
            end else begin
                rd_owner <= OWN_NONE;
            end

            if (core_acc && core_oob) begin
                oob_error_q <= 1'b1;
            end
            core_rdata_q <= core_rdata_c;
            host_rdata_q <= host_rdata_c;
        end
    end

    assign bus.core_stall = core_stall_c;
    assign bus.core_rdata = core_rdata_c;
    assign bus.core_rvld  = core_rvld_c;
    assign bus.oob_error  = oob_error_q;
    assign bus.host_gnt   = host_gnt_c;
    assign bus.host_rdata = host_rdata_c;
    assign bus.host_rvld  = host_rvld_c;
    assign bus.mem_re     = mem_re_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule

// File: tb/tb_linmem_arbiter.sv
// Table-driven bench for linmem_arbiter with a write-first memory model and a
// scoreboard of expected read returns checked one cycle after each accepted read.
module tb_linmem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        string       name;
        logic        cre;
        logic        cwe;
        logic [31:0] ca;
        logic [31:0] cwd;
        logic        hreq;
        logic        hwe;
        logic        hlk;
        logic [9:0]  ha;
        logic [31:0] hwd;
        logic        xst;
        logic        xg;
        logic        xre;
        logic        xwe;
        logic [9:0]  xa;
        logic [31:0] xwd;
        logic        xoob;
    } vec_t;

    typedef struct {
        logic        is_host;
        logic [31:0] data;
        int          due;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        mon_en;
    int          cycle_cnt;
    int          n_checks;
    int          n_fail;
    vec_t        vecs[$];
    sb_t         sb[$];
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    linmem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    linmem_arbiter #(
        .ADDR_WIDTH   (10),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every cycle: compare rvld/rdata against the scoreboard entry due now, if any
    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_c;
            logic        exp_h;
            logic [31:0] exp_d;
            sb_t         e;
            exp_c = 1'b0;
            exp_h = 1'b0;
            exp_d = '0;
            if (sb.size() > 0 && sb[0].due <= cycle_cnt) begin
                e = sb.pop_front();
                exp_c = !e.is_host;
                exp_h = e.is_host;
                exp_d = e.data;
            end
            check($sformatf("core_rvld@%0d", cycle_cnt), {31'd0, bus.core_rvld}, {31'd0, exp_c});
            check($sformatf("host_rvld@%0d", cycle_cnt), {31'd0, bus.host_rvld}, {31'd0, exp_h});
            if (exp_c) check($sformatf("core_rdata@%0d", cycle_cnt), bus.core_rdata, exp_d);
            if (exp_h) check($sformatf("host_rdata@%0d", cycle_cnt), bus.host_rdata, exp_d);
        end
    end

    function automatic vec_t mk(string n, logic cre, logic cwe, logic [31:0] ca, logic [31:0] cwd,
                                logic hreq, logic hwe, logic hlk, logic [9:0] ha, logic [31:0] hwd,
                                logic xst, logic xg, logic xre, logic xwe, logic [9:0] xa,
                                logic [31:0] xwd, logic xoob);
        vec_t v;
        v.name = n;  v.cre = cre;  v.cwe = cwe;  v.ca = ca;   v.cwd = cwd;
        v.hreq = hreq; v.hwe = hwe; v.hlk = hlk; v.ha = ha;   v.hwd = hwd;
        v.xst = xst; v.xg = xg;    v.xre = xre;  v.xwe = xwe; v.xa = xa;
        v.xwd = xwd; v.xoob = xoob;
        return v;
    endfunction

    function automatic vec_t idle(string n, logic hlk, logic xoob);
        return mk(n, L, L, 32'd0, 32'd0, L, L, hlk, 10'd0, 32'd0, L, L, L, L, 10'd0, 32'd0, xoob);
    endfunction

    task automatic drive_idle();
        bus.core_re = L;  bus.core_we = L;  bus.core_addr = '0; bus.core_wdata = '0;
        bus.host_req = L; bus.host_we = L;  bus.host_lock = L;
        bus.host_addr = '0; bus.host_wdata = '0;
    endtask

    task automatic check_output(input vec_t v);
        logic oob;
        check({v.name, ".core_stall"}, {31'd0, bus.core_stall}, {31'd0, v.xst});
        check({v.name, ".host_gnt"},   {31'd0, bus.host_gnt},   {31'd0, v.xg});
        check({v.name, ".mem_re"},     {31'd0, bus.mem_re},     {31'd0, v.xre});
        check({v.name, ".mem_we"},     {31'd0, bus.mem_we},     {31'd0, v.xwe});
        check({v.name, ".oob_error"},  {31'd0, bus.oob_error},  {31'd0, v.xoob});
        if (v.xre || v.xwe) check({v.name, ".mem_addr"}, {22'd0, bus.mem_addr}, {22'd0, v.xa});
        if (v.xwe) check({v.name, ".mem_wdata"}, bus.mem_wdata, v.xwd);
        oob = (v.ca[31:10] != '0);
        if ((v.cre || v.cwe) && !v.xst) begin
            if (v.cwe) begin
                if (!oob) ref_mem[v.ca[9:0]] = v.cwd;
            end else begin
                sb.push_back('{is_host: L, data: oob ? 32'd0 : ref_mem[v.ca[9:0]], due: cycle_cnt + 1});
            end
        end
        if (v.hreq && v.xg) begin
            if (v.hwe) ref_mem[v.ha] = v.hwd;
            else sb.push_back('{is_host: H, data: ref_mem[v.ha], due: cycle_cnt + 1});
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(posedge clk);
        #1;
        bus.core_re = v.cre;   bus.core_we = v.cwe;   bus.core_addr = v.ca; bus.core_wdata = v.cwd;
        bus.host_req = v.hreq; bus.host_we = v.hwe;   bus.host_lock = v.hlk;
        bus.host_addr = v.ha;  bus.host_wdata = v.hwd;
        @(negedge clk);
        check_output(v);
    endtask

    task automatic check_all_zero(input string n);
        check({n, ".core_stall"}, {31'd0, bus.core_stall}, 32'd0);
        check({n, ".host_gnt"},   {31'd0, bus.host_gnt},   32'd0);
        check({n, ".mem_re"},     {31'd0, bus.mem_re},     32'd0);
        check({n, ".mem_we"},     {31'd0, bus.mem_we},     32'd0);
        check({n, ".mem_addr"},   {22'd0, bus.mem_addr},   32'd0);
        check({n, ".oob_error"},  {31'd0, bus.oob_error},  32'd0);
        check({n, ".core_rdata"}, bus.core_rdata,          32'd0);
        check({n, ".host_rdata"}, bus.host_rdata,          32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cycle_cnt = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        bus.mem_rdata = '0;
        drive_idle();
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[5]     = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Plain core read
        vecs.push_back(mk("core_rd5", H, L, 32'd5, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, H, L, 10'd5, 32'd0, L));
        vecs.push_back(idle("idle_a", L, L));

        // Contention: host forced through once the starve count saturates
        for (int i = 0; i < 10; i++) begin
            logic hw;
            hw = (i == 8);
            vecs.push_back(mk($sformatf("starve_%0d", i), H, L, 32'd10, 32'd0, H, L, L, 10'd11, 32'd0,
                              hw, hw, H, L, hw ? 10'd11 : 10'd10, 32'd0, L));
        end
        vecs.push_back(idle("idle_b", L, L));

        // Host exclusive mode: memory init while the core is held off
        vecs.push_back(idle("lock_enter", H, L));
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk($sformatf("lock_wr_%0d", i), H, L, 32'd7, 32'd0, H, H, H, 10'(i), 32'(i * 3),
                              H, H, L, H, 10'(i), 32'(i * 3), L));
        end
        vecs.push_back(mk("unlock", H, L, 32'd7, 32'd0, L, L, L, 10'd0, 32'd0,
                          H, L, L, L, 10'd0, 32'd0, L));
        vecs.push_back(mk("core_rd7", H, L, 32'd7, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, H, L, 10'd7, 32'd0, L));
        vecs.push_back(idle("idle_c", L, L));

        // Out-of-range core read, then sticky error
        vecs.push_back(mk("oob_rd", H, L, 32'h400, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, L, L, 10'd0, 32'd0, L));
        vecs.push_back(idle("oob_sticky1", L, H));
        vecs.push_back(mk("core_rd2", H, L, 32'd2, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, H, L, 10'd2, 32'd0, H));
        vecs.push_back(idle("oob_sticky2", L, H));

        // Back-to-back reads alternating owner
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                vecs.push_back(mk($sformatf("alt_host_%0d", i), L, L, 32'd0, 32'd0, H, L, L, 10'd3, 32'd0,
                                  L, H, H, L, 10'd3, 32'd0, H));
            else
                vecs.push_back(mk($sformatf("alt_core_%0d", i), H, L, 32'd4, 32'd0, L, L, L, 10'd0, 32'd0,
                                  L, L, H, L, 10'd4, 32'd0, H));
        end

        // Write-first turnaround, and a core re+we that must not return data
        vecs.push_back(mk("host_wr20", L, L, 32'd0, 32'd0, H, H, L, 10'd20, 32'h1234_5678,
                          L, H, L, H, 10'd20, 32'h1234_5678, H));
        vecs.push_back(mk("core_rd20", H, L, 32'd20, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, H, L, 10'd20, 32'd0, H));
        vecs.push_back(mk("core_rewe30", H, H, 32'd30, 32'hCAFE_F00D, L, L, L, 10'd0, 32'd0,
                          L, L, L, H, 10'd30, 32'hCAFE_F00D, H));
        vecs.push_back(mk("core_rd30", H, L, 32'd30, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, H, L, 10'd30, 32'd0, H));
        vecs.push_back(idle("idle_d", L, H));
        vecs.push_back(mk("pre_rst_rd5", H, L, 32'd5, 32'd0, L, L, L, 10'd0, 32'd0,
                          L, L, H, L, 10'd5, 32'd0, H));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Reset lands on the cycle the last read would have returned
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_idle();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_mid_rst");
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
